instr_seq_ctrl: RTL and testbench
=================================

# instr_seq_ctrl

Instruction sequencing controller for the simplified RISC CPU. It steps an 8-cycle fetch/execute sequence per instruction. From the latched opcode and the accumulator-zero flag, it generates the strobes for the PC, instruction register, memory and data-bus driver, and the accumulator load enable (`load_acc`, which drives the accumulator's `ena`). It sits between the instruction register and the CPU datapath.

## Interface
Parameters:
- `OPC_W`, default 3: opcode width; only 3 is supported.

Ports:
- `clk`: input, 1 bit. System clock.
- `rst`: input, 1 bit. Reset; synchronous, active-high.
- `ena`: input, 1 bit. Run enable; sampled only at instruction boundaries.
- `opcode`: input, `OPC_W` bits. Opcode field from the instruction register; valid from S2 onward.
- `zero`: input, 1 bit. High when the accumulator equals 0.
- `rd`: output, 1 bit. Memory read strobe.
- `wr`: output, 1 bit. Memory write strobe.
- `load_ir`: output, 1 bit. Instruction register load.
- `inc_pc`: output, 1 bit. PC increment.
- `load_pc`: output, 1 bit. PC load from the operand address.
- `load_acc`: output, 1 bit. Accumulator load enable.
- `datactl_ena`: output, 1 bit. Drives the accumulator onto the data bus.
- `halt`: output, 1 bit. High while halted.
- `busy`: output, 1 bit. High in S0..S7.

## Operation
- States: IDLE, S0..S7, HALTED.
- Opcode encoding: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALU group = ADD/AND/XOR/LDA.
- The clock edge that leaves S2 captures `opcode` into `opc_q` and `zero` into `zero_q`. All S3..S7 decoding uses `opc_q` and `zero_q` only.
- Transitions:
  - IDLE to S0 when `ena`=1.
  - S0 through S6 each advance unconditionally to the next state.
  - S3 goes to HALTED when `opc_q`=HLT.
  - S7 goes to S0 if `ena`=1, else to IDLE.
  - HALTED holds, except as described under Configuration.
- Strobes per state (all other outputs are 0):
  - S0: `rd`, `load_ir`.
  - S1: `rd`, `load_ir`, `inc_pc`.
  - S2: none.
  - S3: `inc_pc` if `opc_q` is not HLT. If HLT, `halt`=1 and there is no `inc_pc`.
  - S4: ALU ops: `rd`. JMP: `load_pc`. STO: `datactl_ena`.
  - S5: ALU ops: `rd`, `load_acc`. JMP: `load_pc`. STO: `wr`, `datactl_ena`. SKZ with `zero_q`=1: `inc_pc`.
  - S6: ALU ops: `rd`. STO: `datactl_ena`.
  - S7: SKZ with `zero_q`=1: `inc_pc`.
- Net effect of SKZ when the accumulator is zero: 2 extra PC increments (S5 and S7), which skips one 16-bit instruction.
- HALTED: `halt`=1 and all strobes are 0.
- `busy`=1 in S0..S7.

## Timing
- All outputs are a Moore decode of the state register plus `opc_q`/`zero_q`. Each output is valid for the entire cycle of its state and is a single-cycle pulse per state.
- One instruction takes exactly 8 clk cycles, S0 to S7. Back-to-back instructions have no bubble while `ena`=1.
- A deasserted `ena` takes effect only in IDLE or S7. Mid-instruction changes to `ena` are ignored.
- Reset, which overrides everything and can occur mid-instruction: the next state is IDLE, `opc_q`=000, `zero_q`=0, and every output is 0, including `halt` and `busy`.
- `wr` and `rd` are never high in the same cycle. `load_pc` and `inc_pc` are never high in the same cycle.

## Configuration
- `INSTR_SEQ_RESUME_EN` defined:
  - Adds input `resume` (1 bit).
  - In HALTED, `resume`=1 moves the FSM to S0 on the next edge, continuing at the current PC.
  - `resume` is ignored in every other state.
- `INSTR_SEQ_RESUME_EN` not defined:
  - The `resume` port does not exist.
  - HALTED is left only by `rst`.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode localparams `OP_HLT`..`OP_JMP`.
  - State encoding enum/localparams `ST_IDLE`, `ST_S0`..`ST_S7`, `ST_HALTED`.
  - The ALU-group membership function.
- Optional combinational sub-module `instr_seq_decode` maps state, `opc_q` and `zero_q` to the strobe vector. The state register and next-state logic stay in the top module.

## Test plan
- Reset, then `ena`=1 with LDA (101) → `rd`+`load_ir` in S0/S1, `inc_pc` in S1 and S3, `rd` in S4..S6, `load_acc` only in S5, and `busy` high for 8 cycles.
- STO (110) → `datactl_ena` in S4..S6 and `wr` only in S5, never overlapping `rd`.
- SKZ (001) with `zero`=1 at the S2 edge → `inc_pc` in S1, S3, S5 and S7 (4 pulses). With `zero`=0 → `inc_pc` in S1 and S3 only.
- JMP (111) → `load_pc` in S4 and S5, with no `inc_pc` in S5 or S7.
- HLT (000) → `halt` rises in S3, the FSM stays in HALTED with all strobes 0 for at least 20 cycles, and `busy`=0. With `INSTR_SEQ_RESUME_EN` defined, pulsing `resume` → S0 with `rd`=1 on the next cycle.
- `rst` asserted in S5 of an ADD → all outputs 0 on the next cycle and no `load_acc` pulse. `ena` dropped in S4 → the instruction completes, then the FSM goes to IDLE after S7.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the simplified RISC CPU: opcodes, sequencer state
// encoding, strobe bundle and the ALU-group helper.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_S0     = 4'd1;
    localparam logic [3:0] ST_S1     = 4'd2;
    localparam logic [3:0] ST_S2     = 4'd3;
    localparam logic [3:0] ST_S3     = 4'd4;
    localparam logic [3:0] ST_S4     = 4'd5;
    localparam logic [3:0] ST_S5     = 4'd6;
    localparam logic [3:0] ST_S6     = 4'd7;
    localparam logic [3:0] ST_S7     = 4'd8;
    localparam logic [3:0] ST_HALTED = 4'd9;

    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
        logic busy;
    } strobe_t;

    // Opcodes that read an operand from memory into the accumulator path.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/instr_seq_decode.sv
// Combinational strobe decode from sequencer state plus the latched opcode
// and zero flag.
module instr_seq_decode
    import cpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] opc_q,
    input  logic       zero_q,
    output strobe_t    strobes
);

    logic alu_op;
    logic skip_taken;

    assign alu_op     = is_alu_op(opc_q);
    assign skip_taken = (opc_q == OP_SKZ) && zero_q;

    always_comb begin
        strobes = '0;
        strobes.busy = (state >= ST_S0) && (state <= ST_S7);
        case (state)
            ST_S0: begin
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
            end
            ST_S1: begin
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
                strobes.inc_pc  = 1'b1;
            end
            ST_S3: begin
                strobes.inc_pc = (opc_q != OP_HLT);
                strobes.halt   = (opc_q == OP_HLT);
            end
            ST_S4: begin
                strobes.rd          = alu_op;
                strobes.load_pc     = (opc_q == OP_JMP);
                strobes.datactl_ena = (opc_q == OP_STO);
            end
            ST_S5: begin
                strobes.rd          = alu_op;
                strobes.load_acc    = alu_op;
                strobes.load_pc     = (opc_q == OP_JMP);
                strobes.wr          = (opc_q == OP_STO);
                strobes.datactl_ena = (opc_q == OP_STO);
                strobes.inc_pc      = skip_taken;
            end
            ST_S6: begin
                strobes.rd          = alu_op;
                strobes.datactl_ena = (opc_q == OP_STO);
            end
            ST_S7: begin
                strobes.inc_pc = skip_taken;
            end
            ST_HALTED: begin
                strobes.halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// 8-cycle fetch/execute sequencer for the simplified RISC CPU.
// Optional INSTR_SEQ_RESUME_EN adds a resume input that restarts from HALTED.
module instr_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
`ifdef INSTR_SEQ_RESUME_EN
    input  logic             resume,
`endif
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             halt,
    output logic             busy
);

    logic [3:0]       state_reg;
    logic [3:0]       state_next;
    logic [OPC_W-1:0] opc_q;
    logic             zero_q;
    strobe_t          strobes;
    strobe_t          strobes_out;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = ena ? ST_S0 : ST_IDLE;
            ST_S0, ST_S1, ST_S2, ST_S4, ST_S5, ST_S6:
                       state_next = state_reg + 4'd1;
            ST_S3:     state_next = (opc_q == OP_HLT) ? ST_HALTED : ST_S4;
            ST_S7:     state_next = ena ? ST_S0 : ST_IDLE;
            ST_HALTED: begin
`ifdef INSTR_SEQ_RESUME_EN
                if (resume) begin
                    state_next = ST_S0;
                end
`endif
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            opc_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Opcode and zero flag are frozen for the rest of the instruction.
            if (state_reg == ST_S2) begin
                opc_q  <= opcode;
                zero_q <= zero;
            end
        end
    end

    instr_seq_decode u_decode (
        .state   (state_reg),
        .opc_q   (opc_q),
        .zero_q  (zero_q),
        .strobes (strobes)
    );

    // Reset blanks every strobe immediately so an interrupted cycle cannot
    // leak a write, load or PC update.
    assign strobes_out = rst ? '0 : strobes;

    assign rd          = strobes_out.rd;
    assign wr          = strobes_out.wr;
    assign load_ir     = strobes_out.load_ir;
    assign inc_pc      = strobes_out.inc_pc;
    assign load_pc     = strobes_out.load_pc;
    assign load_acc    = strobes_out.load_acc;
    assign datactl_ena = strobes_out.datactl_ena;
    assign halt        = strobes_out.halt;
    assign busy        = strobes_out.busy;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: stimulus queues the expected strobe
// vector per cycle, a negedge monitor pops and compares.
module tb_instr_seq_ctrl;

    // Strobe vector bit order: {rd,wr,load_ir,inc_pc,load_pc,load_acc,datactl_ena,halt,busy}
    localparam logic [8:0] RD  = 9'b1_0000_0000;
    localparam logic [8:0] WR  = 9'b0_1000_0000;
    localparam logic [8:0] LIR = 9'b0_0100_0000;
    localparam logic [8:0] INC = 9'b0_0010_0000;
    localparam logic [8:0] LPC = 9'b0_0001_0000;
    localparam logic [8:0] LAC = 9'b0_0000_1000;
    localparam logic [8:0] DCT = 9'b0_0000_0100;
    localparam logic [8:0] HLT = 9'b0_0000_0010;
    localparam logic [8:0] BSY = 9'b0_0000_0001;

    localparam logic [8:0] V_ALU [8] = '{RD|LIR|BSY, RD|LIR|INC|BSY, BSY, INC|BSY,
                                         RD|BSY, RD|LAC|BSY, RD|BSY, BSY};
    localparam logic [8:0] V_STO [8] = '{RD|LIR|BSY, RD|LIR|INC|BSY, BSY, INC|BSY,
                                         DCT|BSY, WR|DCT|BSY, DCT|BSY, BSY};
    localparam logic [8:0] V_SKZ1 [8] = '{RD|LIR|BSY, RD|LIR|INC|BSY, BSY, INC|BSY,
                                          BSY, INC|BSY, BSY, INC|BSY};
    localparam logic [8:0] V_SKZ0 [8] = '{RD|LIR|BSY, RD|LIR|INC|BSY, BSY, INC|BSY,
                                          BSY, BSY, BSY, BSY};
    localparam logic [8:0] V_JMP [8] = '{RD|LIR|BSY, RD|LIR|INC|BSY, BSY, INC|BSY,
                                         LPC|BSY, LPC|BSY, BSY, BSY};
    localparam logic [8:0] V_HLT [4] = '{RD|LIR|BSY, RD|LIR|INC|BSY, BSY, HLT|BSY};

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
`ifdef INSTR_SEQ_RESUME_EN
    logic       resume;
`endif
    logic rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, busy;

    logic [8:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_seq_ctrl #(.OPC_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
`ifdef INSTR_SEQ_RESUME_EN
        .resume      (resume),
`endif
        .opcode      (opcode),
        .zero        (zero),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .busy        (busy)
    );

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] e;
        act = {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, busy};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL strobes t=%0t: actual=%09b required=%09b", $time, act, e);
            end
        end
        checks++;
        if ((rd && wr) || (load_pc && inc_pc)) begin
            errors++;
            $display("FAIL exclusive t=%0t: rd=%b wr=%b load_pc=%b inc_pc=%b (required no overlap)",
                     $time, rd, wr, load_pc, inc_pc);
        end
    end

    // Called at posedge+1: queue the expectation for this cycle, then advance.
    task automatic cyc(input logic [8:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input int drop_at, input logic [8:0] v [8]);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                opcode = op;
                zero   = z;
            end
            if (i == 3) begin
                opcode = ~op;
                zero   = ~z;
            end
            if (i >= drop_at) ena = 1'b0;
            cyc(v[i]);
        end
        $display("instr %s op=%03b zero=%b ena_drop=%0d issued", name, op, z, drop_at);
    endtask

    initial begin
        int guard;
        rst    = 1'b1;
        ena    = 1'b0;
        opcode = 3'b000;
        zero   = 1'b0;
`ifdef INSTR_SEQ_RESUME_EN
        resume = 1'b0;
`endif
        @(posedge clk);
        #1;
        cyc(9'b0);
        rst = 1'b0;
        ena = 1'b1;
        cyc(9'b0);

        run_instr("LDA",      3'b101, 1'b0, 8, V_ALU);
        run_instr("STO",      3'b110, 1'b0, 8, V_STO);
        run_instr("SKZ_z1",   3'b001, 1'b1, 8, V_SKZ1);
        run_instr("SKZ_z0",   3'b001, 1'b0, 8, V_SKZ0);
        run_instr("JMP",      3'b111, 1'b0, 8, V_JMP);
        run_instr("ADD_drop", 3'b010, 1'b0, 4, V_ALU);

        cyc(9'b0);
        cyc(9'b0);
        $display("instr IDLE hold with ena=0 issued");
        ena = 1'b1;
        cyc(9'b0);

        // ADD interrupted by reset in S5.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) opcode = 3'b010;
            cyc(V_ALU[i]);
        end
        rst = 1'b1;
        cyc(9'b0);
        rst = 1'b0;
        ena = 1'b0;
        cyc(9'b0);
        $display("instr ADD_rst_in_S5 issued");
        ena = 1'b1;
        cyc(9'b0);

        for (int i = 0; i < 4; i++) begin
            if (i == 2) opcode = 3'b000;
            if (i == 3) opcode = 3'b101;
            cyc(V_HLT[i]);
        end
        for (int i = 0; i < 20; i++) cyc(HLT);
        $display("instr HLT issued, 20 halted cycles");

`ifdef INSTR_SEQ_RESUME_EN
        resume = 1'b1;
        cyc(HLT);
        resume = 1'b0;
        cyc(RD | LIR | BSY);
        $display("instr RESUME issued");
`endif
        rst = 1'b1;
        cyc(9'b0);
        rst = 1'b0;
        ena = 1'b0;
        cyc(9'b0);
        cyc(9'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
